// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, word-length codes and the
// frame parity helper, kept here so the receiver can reuse them.
package uart_pkg;

   typedef logic [2:0] uart_tx_state_e;

   localparam uart_tx_state_e TX_IDLE   = 3'd0;
   localparam uart_tx_state_e TX_START  = 3'd1;
   localparam uart_tx_state_e TX_DATA   = 3'd2;
   localparam uart_tx_state_e TX_PARITY = 3'd3;
   localparam uart_tx_state_e TX_STOP   = 3'd4;

   localparam logic [1:0] WLEN_5 = 2'b00;
   localparam logic [1:0] WLEN_6 = 2'b01;
   localparam logic [1:0] WLEN_7 = 2'b10;
   localparam logic [1:0] WLEN_8 = 2'b11;

   function automatic logic [7:0] wlen_mask(input logic [1:0] wlen);
      logic [7:0] mask;
      case (wlen)
         WLEN_5:  mask = 8'h1F;
         WLEN_6:  mask = 8'h3F;
         WLEN_7:  mask = 8'h7F;
         WLEN_8:  mask = 8'hFF;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

   // Parity covers only the bits actually placed on the line.
   function automatic logic frame_parity(input logic [7:0] data,
                                         input logic [1:0] wlen,
                                         input logic       eps,
                                         input logic       sps);
      logic par;
      if (sps) begin
         par = ~eps;
      end else if (eps) begin
         par = ^(data & wlen_mask(wlen));
      end else begin
         par = ~(^(data & wlen_mask(wlen)));
      end
      return par;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: frames a byte as start, 5..8 data bits LSB first, optional
// parity and 1 or 2 stop bits, each bit lasting OVERSAMPLE baud ticks.
module uart_tx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       baud_tick_i,
   input  logic       uart_tx_en_i,
   input  logic [1:0] cr_wlen_i,
   input  logic       cr_pen_i,
   input  logic       cr_eps_i,
   input  logic       cr_sps_i,
   input  logic       cr_stp2_i,
   input  logic       cr_brk_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       uart_tx_o,
   output logic       tx_busy_o
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_ZERO = {OS_W{1'b0}};
   localparam logic [OS_W-1:0] OS_ONE  = {{(OS_W-1){1'b0}}, 1'b1};

   uart_tx_state_e  state_r;
   uart_tx_state_e  state_nxt_s;
   logic [OS_W-1:0] os_cnt_r;
   logic [OS_W-1:0] os_cnt_nxt_s;
   logic [2:0]      bit_cnt_r;
   logic [2:0]      bit_cnt_nxt_s;
   logic [7:0]      data_r;
   logic [1:0]      wlen_r;
   logic            pen_r;
   logic            eps_r;
   logic            sps_r;
   logic            stp2_r;
   logic            line_r;
   logic            line_nxt_s;
   logic            busy_r;
   logic            xfer_s;
   logic            bit_done_s;
   logic [2:0]      last_bit_s;

   assign tx_ready_o = ~rst_i & (state_r == TX_IDLE) & uart_tx_en_i;
   assign xfer_s     = tx_valid_i & tx_ready_o;
   assign bit_done_s = baud_tick_i & (os_cnt_r == OS_LAST);
   assign last_bit_s = {1'b1, wlen_r};
   assign uart_tx_o  = line_r;
   assign tx_busy_o  = busy_r;

   // Frame sequencing: state, per-bit oversample counter and data/stop bit counter
   always_comb begin
      state_nxt_s   = state_r;
      bit_cnt_nxt_s = bit_cnt_r;
      if (baud_tick_i) begin
         os_cnt_nxt_s = os_cnt_r + OS_ONE;
      end else begin
         os_cnt_nxt_s = os_cnt_r;
      end
      case (state_r)
         TX_IDLE: begin
            os_cnt_nxt_s  = OS_ZERO;
            bit_cnt_nxt_s = 3'd0;
            if (xfer_s) begin
               state_nxt_s = TX_START;
            end else begin
               state_nxt_s = TX_IDLE;
            end
         end
         TX_START: begin
            if (bit_done_s) begin
               state_nxt_s   = TX_DATA;
               os_cnt_nxt_s  = OS_ZERO;
               bit_cnt_nxt_s = 3'd0;
            end else begin
               state_nxt_s = TX_START;
            end
         end
         TX_DATA: begin
            if (bit_done_s) begin
               os_cnt_nxt_s = OS_ZERO;
               if (bit_cnt_r == last_bit_s) begin
                  bit_cnt_nxt_s = 3'd0;
                  if (pen_r) begin
                     state_nxt_s = TX_PARITY;
                  end else begin
                     state_nxt_s = TX_STOP;
                  end
               end else begin
                  bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                  state_nxt_s   = TX_DATA;
               end
            end else begin
               state_nxt_s = TX_DATA;
            end
         end
         TX_PARITY: begin
            if (bit_done_s) begin
               state_nxt_s   = TX_STOP;
               os_cnt_nxt_s  = OS_ZERO;
               bit_cnt_nxt_s = 3'd0;
            end else begin
               state_nxt_s = TX_PARITY;
            end
         end
         TX_STOP: begin
            if (bit_done_s) begin
               os_cnt_nxt_s = OS_ZERO;
               // bit_cnt counts stop bits here; a second one only when stp2 is set
               if (stp2_r && (bit_cnt_r == 3'd0)) begin
                  bit_cnt_nxt_s = 3'd1;
                  state_nxt_s   = TX_STOP;
               end else begin
                  bit_cnt_nxt_s = 3'd0;
                  state_nxt_s   = TX_IDLE;
               end
            end else begin
               state_nxt_s = TX_STOP;
            end
         end
         default: begin
            state_nxt_s   = TX_IDLE;
            os_cnt_nxt_s  = OS_ZERO;
            bit_cnt_nxt_s = 3'd0;
         end
      endcase
   end

   // Line value for the cycle the FSM enters next; break overrides everything
   always_comb begin
      if (cr_brk_i) begin
         line_nxt_s = 1'b0;
      end else begin
         case (state_nxt_s)
            TX_IDLE:   line_nxt_s = 1'b1;
            TX_START:  line_nxt_s = 1'b0;
            TX_DATA:   line_nxt_s = data_r[bit_cnt_nxt_s];
            TX_PARITY: line_nxt_s = frame_parity(data_r, wlen_r, eps_r, sps_r);
            TX_STOP:   line_nxt_s = 1'b1;
            default:   line_nxt_s = 1'b1;
         endcase
      end
   end

   // FSM, counters and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r   <= TX_IDLE;
         os_cnt_r  <= OS_ZERO;
         bit_cnt_r <= 3'd0;
         line_r    <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         os_cnt_r  <= os_cnt_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         line_r    <= line_nxt_s;
         busy_r    <= (state_nxt_s != TX_IDLE);
      end
   end

   // Byte and framing fields captured on transfer, frozen for the whole frame
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_r <= 8'h00;
         wlen_r <= WLEN_8;
         pen_r  <= 1'b0;
         eps_r  <= 1'b0;
         sps_r  <= 1'b0;
         stp2_r <= 1'b0;
      end else if (xfer_s) begin
         data_r <= tx_data_i;
         wlen_r <= cr_wlen_i;
         pen_r  <= cr_pen_i;
         eps_r  <= cr_eps_i;
         sps_r  <= cr_sps_i;
         stp2_r <= cr_stp2_i;
      end else begin
         data_r <= data_r;
         wlen_r <= wlen_r;
         pen_r  <= pen_r;
         eps_r  <= eps_r;
         sps_r  <= sps_r;
         stp2_r <= stp2_r;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with OVERSAMPLE=16; outputs are
// sampled on the falling clock edge against hand-computed frame bit patterns.
module tb_uart_tx;

   logic       clk;
   logic       rst_i;
   logic       baud_tick_i;
   logic       uart_tx_en_i;
   logic [1:0] cr_wlen_i;
   logic       cr_pen_i;
   logic       cr_eps_i;
   logic       cr_sps_i;
   logic       cr_stp2_i;
   logic       cr_brk_i;
   logic [7:0] tx_data_i;
   logic       tx_valid_i;
   logic       tx_ready_o;
   logic       uart_tx_o;
   logic       tx_busy_o;

   int total = 0;
   int bad   = 0;

   uart_tx #(.OVERSAMPLE(16)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .baud_tick_i  (baud_tick_i),
      .uart_tx_en_i (uart_tx_en_i),
      .cr_wlen_i    (cr_wlen_i),
      .cr_pen_i     (cr_pen_i),
      .cr_eps_i     (cr_eps_i),
      .cr_sps_i     (cr_sps_i),
      .cr_stp2_i    (cr_stp2_i),
      .cr_brk_i     (cr_brk_i),
      .tx_data_i    (tx_data_i),
      .tx_valid_i   (tx_valid_i),
      .tx_ready_o   (tx_ready_o),
      .uart_tx_o    (uart_tx_o),
      .tx_busy_o    (tx_busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called on a falling edge; afterwards the framing inputs are scrambled to prove they were latched.
   task automatic start_frame(input logic [7:0] data, input logic [1:0] wlen,
                              input logic pen, input logic eps, input logic sps,
                              input logic stp2);
      tx_data_i  = data;
      cr_wlen_i  = wlen;
      cr_pen_i   = pen;
      cr_eps_i   = eps;
      cr_sps_i   = sps;
      cr_stp2_i  = stp2;
      tx_valid_i = 1'b1;
      #1;
      chk("ready_before_xfer", {31'd0, tx_ready_o}, 32'd1);
      next_cycle();
      tx_valid_i = 1'b0;
      tx_data_i  = ~data;
      cr_wlen_i  = ~wlen;
      cr_pen_i   = ~pen;
      cr_eps_i   = ~eps;
      cr_sps_i   = ~sps;
      cr_stp2_i  = ~stp2;
   endtask

   // Each expected bit must hold for exactly 16 samples with busy=1 and ready=0.
   task automatic check_frame(input string tag, input logic [15:0] bits, input int n,
                              input int drop_k, input logic end_line);
      int errs;
      for (int i = 0; i < n; i++) begin
         errs = 0;
         for (int j = 0; j < 16; j++) begin
            if (uart_tx_o !== bits[i] || tx_busy_o !== 1'b1 || tx_ready_o !== 1'b0) errs++;
            if (i * 16 + j == drop_k) uart_tx_en_i = 1'b0;
            next_cycle();
         end
         chk($sformatf("%s_bit%0d_errs", tag, i), errs, 32'd0);
      end
      chk({tag, "_end_line"}, {31'd0, uart_tx_o}, {31'd0, end_line});
      chk({tag, "_end_busy"}, {31'd0, tx_busy_o}, 32'd0);
   endtask

   initial begin
      rst_i        = 1'b1;
      baud_tick_i  = 1'b1;
      uart_tx_en_i = 1'b1;
      cr_wlen_i    = 2'b11;
      cr_pen_i     = 1'b0;
      cr_eps_i     = 1'b0;
      cr_sps_i     = 1'b0;
      cr_stp2_i    = 1'b0;
      cr_brk_i     = 1'b0;
      tx_data_i    = 8'h00;
      tx_valid_i   = 1'b0;

      // Reset state
      repeat (3) next_cycle();
      chk("rst_line", {31'd0, uart_tx_o}, 32'd1);
      chk("rst_busy", {31'd0, tx_busy_o}, 32'd0);
      chk("rst_ready", {31'd0, tx_ready_o}, 32'd0);
      rst_i = 1'b0;
      #1;
      chk("ready_after_rst", {31'd0, tx_ready_o}, 32'd1);
      next_cycle();

      // 8N1 0x55
      start_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      check_frame("f8n1_55", 16'h02AA, 10, -1, 1'b1);

      // Back-to-back 7E2 0x41, transferred in the single idle cycle
      start_frame(8'h41, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
      check_frame("f7e2_41", 16'h0682, 11, -1, 1'b1);

      // 5-bit stick parity eps=1, 0xFF
      start_frame(8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
      check_frame("f5s_ff", 16'h00BE, 8, -1, 1'b1);

      // 6E1 0xED: upper bits ignored, parity over 0x2D
      start_frame(8'hED, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
      check_frame("f6e1_ed", 16'h015A, 9, -1, 1'b1);

      // 8O1 0xA5 with enable dropped during data bit 2
      start_frame(8'hA5, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      check_frame("f8o1_a5", 16'h074A, 11, 48, 1'b1);
      tx_data_i  = 8'h12;
      tx_valid_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("dis_ready_c%0d", c), {31'd0, tx_ready_o}, 32'd0);
         chk($sformatf("dis_busy_c%0d", c), {31'd0, tx_busy_o}, 32'd0);
         next_cycle();
      end
      tx_valid_i   = 1'b0;
      uart_tx_en_i = 1'b1;
      #1;
      chk("en_back_ready", {31'd0, tx_ready_o}, 32'd1);
      next_cycle();

      // Reset pulsed in the middle of data bit 1 of 0x00
      start_frame(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (39) next_cycle();
      chk("pre_rst_line", {31'd0, uart_tx_o}, 32'd0);
      chk("pre_rst_busy", {31'd0, tx_busy_o}, 32'd1);
      rst_i = 1'b1;
      next_cycle();
      chk("mid_rst_line", {31'd0, uart_tx_o}, 32'd1);
      chk("mid_rst_busy", {31'd0, tx_busy_o}, 32'd0);
      chk("mid_rst_ready", {31'd0, tx_ready_o}, 32'd0);
      rst_i = 1'b0;
      next_cycle();
      start_frame(8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      check_frame("post_rst_96", 16'h032C, 10, -1, 1'b1);

      // Break held across a whole 8N1 frame of 0xFF
      cr_brk_i = 1'b1;
      next_cycle();
      chk("brk_idle_line", {31'd0, uart_tx_o}, 32'd0);
      chk("brk_idle_busy", {31'd0, tx_busy_o}, 32'd0);
      start_frame(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      check_frame("brk_ff", 16'h0000, 10, -1, 1'b0);
      cr_brk_i = 1'b0;
      next_cycle();
      chk("brk_release_line", {31'd0, uart_tx_o}, 32'd1);

      // No baud ticks: the start bit must not advance
      baud_tick_i = 1'b0;
      start_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (40) next_cycle();
      chk("notick_line", {31'd0, uart_tx_o}, 32'd0);
      chk("notick_busy", {31'd0, tx_busy_o}, 32'd1);
      baud_tick_i = 1'b1;
      check_frame("tick_resume_3c", 16'h0278, 10, -1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
